// File: rtl/v1_pulse_gen_pkg.sv
// v1_pulse_gen_pkg: default settings and FSM state type shared
// by the synthetic detector-pulse source and its period timer.
package v1_pulse_gen_pkg;

  localparam int V1_SIZE_ADC_DATA = 14;
  localparam int V1_FRAC_BITS     = 8;
  localparam int V1_RISE_SHIFT    = 2;
  localparam int V1_DECAY_SHIFT   = 4;
  localparam int V1_HOLDOFF       = 16;
  localparam int V1_PERIOD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISE,
    ST_DECAY,
    ST_HOLDOFF
  } pulse_state_t;

endpackage

// File: rtl/v1_period_timer.sv
// v1_period_timer: auto-trigger interval counter with reload on
// expiry, clear while disabled and a minimum period of 2.
module v1_period_timer
  import v1_pulse_gen_pkg::*;
#(
  parameter int PERIOD_W = V1_PERIOD_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                expired_o
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic [PERIOD_W-1:0] last;

  // >= keeps a shortened period from running the full counter range
  assign last = (period_i < PERIOD_W'(2)) ? PERIOD_W'(1)
                                          : period_i - PERIOD_W'(1);

  assign expired_o = en_i && (cnt_q >= last);

  always_comb begin
    cnt_d = cnt_q + PERIOD_W'(1);
    if (!en_i || expired_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/v1_pulse_gen.sv
// v1_pulse_gen: linear-rise / exponential-decay pulse source that
// emulates the ADC feeding the variant-1 shaping filter.
module v1_pulse_gen
  import v1_pulse_gen_pkg::*;
#(
  parameter int SIZE_ADC_DATA = V1_SIZE_ADC_DATA,
  parameter int FRAC_BITS     = V1_FRAC_BITS,
  parameter int RISE_SHIFT    = V1_RISE_SHIFT,
  parameter int DECAY_SHIFT   = V1_DECAY_SHIFT,
  parameter int HOLDOFF       = V1_HOLDOFF,
  parameter int PERIOD_W      = V1_PERIOD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     auto_en,
  input  logic [PERIOD_W-1:0]      period,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic [SIZE_ADC_DATA-1:0] baseline,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     busy,
  output logic                     pulse_start,
  output logic                     missed
);

  localparam int ACC_W  = SIZE_ADC_DATA + FRAC_BITS;
  localparam int RC_W   = RISE_SHIFT + 1;
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  localparam logic [RC_W-1:0] RISE_LAST =
    RC_W'((1 << RISE_SHIFT) - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLDOFF - 1);

  pulse_state_t             state_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         step_q;
  logic [RC_W-1:0]          rise_cnt_q;
  logic [HOLD_W-1:0]        hold_cnt_q;
  logic [SIZE_ADC_DATA-1:0] output_q;
  logic                     busy_q;
  logic                     pulse_start_q;
  logic                     missed_q;

  logic                     auto_exp;
  logic                     trigger;
  logic [ACC_W-1:0]         step_new;
  logic [ACC_W-1:0]         decay_sub;
  logic [SIZE_ADC_DATA-1:0] acc_int;
  logic [SIZE_ADC_DATA:0]   sum;
  logic [SIZE_ADC_DATA-1:0] sat_sum;

  v1_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .en_i      (auto_en),
    .period_i  (period),
    .expired_o (auto_exp)
  );

  assign trigger   = start | auto_exp;
  assign step_new  = {amplitude, {FRAC_BITS{1'b0}}} >> RISE_SHIFT;
  assign decay_sub = acc_q >> DECAY_SHIFT;
  assign acc_int   = acc_q[ACC_W-1:FRAC_BITS];

  // one extra bit so the baseline + pulse sum clamps instead of wrapping
  assign sum     = {1'b0, baseline} + {1'b0, acc_int};
  assign sat_sum = sum[SIZE_ADC_DATA] ? '1 : sum[SIZE_ADC_DATA-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      step_q        <= '0;
      rise_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      output_q      <= '0;
      busy_q        <= 1'b0;
      pulse_start_q <= 1'b0;
      missed_q      <= 1'b0;
    end else begin
      output_q      <= sat_sum;
      pulse_start_q <= 1'b0;
      missed_q      <= trigger && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (trigger) begin
            acc_q         <= step_new;
            step_q        <= step_new;
            rise_cnt_q    <= RC_W'(1);
            pulse_start_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_RISE;
          end
        end
        ST_RISE: begin
          acc_q      <= acc_q + step_q;
          rise_cnt_q <= rise_cnt_q + RC_W'(1);
          if (rise_cnt_q == RISE_LAST) begin
            state_q <= ST_DECAY;
          end
        end
        ST_DECAY: begin
          if (acc_int == '0) begin
            acc_q      <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_HOLDOFF;
          end else begin
            acc_q <= acc_q - decay_sub;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == HOLD_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign output_data = output_q;
  assign busy        = busy_q;
  assign pulse_start = pulse_start_q;
  assign missed      = missed_q;

endmodule

// File: tb/tb_v1_pulse_gen.sv
// tb_v1_pulse_gen: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based pulse model.
module tb_v1_pulse_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        auto_en;
  logic [15:0] period;
  logic [13:0] amplitude;
  logic [13:0] baseline;
  logic [13:0] output_data;
  logic        busy;
  logic        pulse_start;
  logic        missed;

  always #5 clk = ~clk;

  v1_pulse_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .auto_en     (auto_en),
    .period      (period),
    .amplitude   (amplitude),
    .baseline    (baseline),
    .output_data (output_data),
    .busy        (busy),
    .pulse_start (pulse_start),
    .missed      (missed)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int unsigned acc_m  = 0;
  bit          busy_m = 0;
  bit          ps_m   = 0;
  bit          ms_m   = 0;
  int unsigned out_m  = 0;
  int unsigned q[$];
  bit          armed    = 0;
  int          next_exp = 0;

  int ps_cnt = 0;
  int ms_cnt = 0;
  int unsigned peak = 0;
  int unsigned low  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d",
             tag, obs, exp, cyc);
    end
  endtask

  // whole pulse as the sequence of accumulator values after each edge
  task automatic build(input int unsigned amp);
    int unsigned s;
    int unsigned a;
    s = (amp << 8) >> 2;
    for (int k = 1; k <= 4; k++) q.push_back(s * k);
    a = 4 * s;
    while ((a >> 8) != 0) begin
      a = a - (a >> 4);
      q.push_back(a);
    end
    repeat (16) q.push_back(0);
  endtask

  task automatic model_edge();
    int unsigned nxt;
    bit          expd;
    bit          trig;
    int          p;
    if (reset) begin
      q.delete();
      acc_m = 0; busy_m = 0; ps_m = 0; ms_m = 0; out_m = 0;
      armed = 0;
      return;
    end
    nxt = baseline + (acc_m >> 8);
    if (nxt > 16383) nxt = 16383;
    p = (period < 2) ? 2 : int'(period);
    expd = 0;
    if (auto_en) begin
      if (!armed) begin
        armed = 1;
        next_exp = cyc + p - 1;
      end
      if (cyc == next_exp) begin
        expd = 1;
        next_exp += p;
      end
    end else begin
      armed = 0;
    end
    trig = start || expd;
    ps_m = trig && !busy_m;
    ms_m = trig && busy_m;
    if (ps_m) build(amplitude);
    if (q.size() > 0) begin
      acc_m = q.pop_front();
      busy_m = 1;
    end else begin
      acc_m = 0;
      busy_m = 0;
    end
    out_m = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk("output_data", output_data, out_m);
    chk("busy", busy, busy_m);
    chk("pulse_start", pulse_start, ps_m);
    chk("missed", missed, ms_m);
    if (pulse_start === 1'b1) ps_cnt++;
    if (missed === 1'b1) ms_cnt++;
    if (busy === 1'b1 && output_data > peak) peak = output_data;
    if (busy === 1'b1 && output_data < low) low = output_data;
  endtask

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int exp1[5];
    int unsigned prev;
    int nonmono;
    int hold_len;
    int n;
    int ms0;
    int k0;
    exp1 = '{356, 612, 868, 1124, 1060};

    reset = 1; start = 0; auto_en = 0; period = 200;
    amplitude = 0; baseline = 0;
    repeat (3) tick();
    chk("reset_out", output_data, 0);
    chk("reset_busy", busy, 0);

    // rise profile
    baseline = 100; amplitude = 1024; reset = 0;
    tick();
    chk("first_baseline", output_data, 100);
    start = 1;
    tick();
    start = 0;
    amplitude = 5;
    chk("ps_e0", pulse_start, 1);
    chk("busy_e0", busy, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rise_profile", output_data, exp1[k]);
      chk("ps_once", pulse_start, 0);
    end

    // full decay and holdoff length
    prev = output_data; nonmono = 0; hold_len = 0; n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      if (output_data > prev) nonmono++;
      if (busy === 1'b1 && output_data == 100) hold_len++;
      prev = output_data;
      n++;
    end
    chk("decay_ends", busy, 0);
    chk("decay_monotonic", nonmono, 0);
    chk("decay_final", output_data, 100);
    chk("holdoff_len", hold_len, 16);

    // start on first idle cycle, then missed in decay and holdoff
    amplitude = 1024; ms0 = ms_cnt;
    start = 1;
    tick();
    start = 0;
    chk("restart_ps", pulse_start, 1);
    repeat (30) tick();
    start = 1;
    tick();
    start = 0;
    chk("missed_decay", missed, 1);
    n = 0;
    while (!(busy === 1'b1 && output_data == 100) && n < 400) begin
      tick();
      n++;
    end
    chk("reach_holdoff", output_data, 100);
    start = 1;
    tick();
    start = 0;
    chk("missed_holdoff", missed, 1);
    run_until_idle("missed_pulse_ends");
    chk("missed_count", ms_cnt - ms0, 2);

    // saturation
    baseline = 16000; amplitude = 1000; peak = 0; low = 16383;
    start = 1;
    tick();
    start = 0;
    run_until_idle("sat_ends");
    chk("sat_peak", peak, 16383);
    chk("sat_no_wrap", low >= 16000, 1);

    // auto mode, period 200, one coinciding start
    baseline = 100; amplitude = 1024; ps_cnt = 0; ms0 = ms_cnt;
    auto_en = 1; period = 200; k0 = cyc;
    for (int i = 0; i < 650; i++) begin
      start = (cyc == k0 + 399);
      tick();
      if (cyc == k0 + 400) begin
        chk("coincide_ps", pulse_start, 1);
        chk("coincide_missed", missed, 0);
      end
    end
    start = 0;
    chk("auto_pulses", ps_cnt, 3);
    chk("auto_missed", ms_cnt - ms0, 0);
    auto_en = 0;
    run_until_idle("auto_ends");

    // period 1 behaves as 2
    period = 1; amplitude = 0;
    tick();
    auto_en = 1;
    tick();
    chk("p1_not_first", pulse_start, 0);
    tick();
    chk("p1_fires_2nd", pulse_start, 1);
    repeat (60) tick();
    auto_en = 0;
    run_until_idle("p1_ends");

    // reset at the peak
    amplitude = 1024;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    chk("pre_reset_peak", output_data, 1124);
    reset = 1;
    tick();
    chk("mid_reset_out", output_data, 0);
    chk("mid_reset_busy", busy, 0);
    reset = 0;
    tick();
    chk("post_reset_base", output_data, 100);
    tick();
    chk("no_residual", output_data, 100);
    start = 1;
    tick();
    start = 0;
    chk("post_reset_ps", pulse_start, 1);
    run_until_idle("post_reset_ends");

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0)
        amplitude = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 49) == 0)
        baseline = ($urandom_range(0, 3) == 0) ?
                   14'($urandom_range(15000, 16383)) :
                   14'($urandom_range(0, 2000));
      if (auto_en) begin
        if ($urandom_range(0, 199) == 0) auto_en = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        period = 16'($urandom_range(0, 60));
      end else if ($urandom_range(0, 49) == 0) begin
        auto_en = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
